piso_shifter: RTL and testbench

- Parallel-in/serial-out serializer that sits directly upstream of the 4-bit SIPO deserializer.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on data_out, with frame markers.
- Supports back-to-back words with no idle gap.
- data_out/out_valid connect straight to the deserializer's serial input/enable.

---
 rtl/piso_shifter.sv | 143 ++++++++++++++
 tb/tb_piso_shifter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in/serial-out serializer with frame_start/frame_done markers; build option PISO_PARITY_EN.
// Latency: word accepted at edge N shows its first bit the cycle after N; frame is WIDTH cycles (+1 parity bit when enabled).
// Backpressure: load_ready only in IDLE or on the final frame bit; load_valid is ignored otherwise and the source must hold the word.
module piso_shifter #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             data_out,
    output logic             out_valid,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

`ifdef PISO_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    localparam bit PAR_EN = 1'b0;
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] sr_q;
    logic [CW-1:0]    cnt_q;
    logic             data_out_q;
    logic             out_valid_q;
    logic             frame_start_q;
    logic             frame_done_q;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    logic [WIDTH-1:0] load_shift_d;
    logic [WIDTH-1:0] sr_shift_d;
    logic             load_first_d;
    logic             sr_next_d;
    logic             accept;

    // Bit-order selection: the bit to drive next, and the remaining bits left behind it.
    always_comb begin
        if (MSB_FIRST) begin
            load_first_d = load_data[WIDTH-1];
            load_shift_d = load_data << 1;
            sr_next_d    = sr_q[WIDTH-1];
            sr_shift_d   = sr_q << 1;
        end else begin
            load_first_d = load_data[0];
            load_shift_d = load_data >> 1;
            sr_next_d    = sr_q[0];
            sr_shift_d   = sr_q >> 1;
        end
    end

    // Ready in IDLE or on the final frame bit, so a follow-on word chains with no idle gap.
    always_comb begin
        load_ready = 1'b0;
        case (state_q)
            IDLE:    load_ready = 1'b1;
            SHIFT:   load_ready = (cnt_q == LAST) && !PAR_EN;
`ifdef PISO_PARITY_EN
            PARITY:  load_ready = 1'b1;
`endif
            default: load_ready = 1'b0;
        endcase
    end

    assign accept = load_valid && load_ready;

    // Frame sequencer: every serial output is registered; an accept always restarts at bit 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            cnt_q         <= '0;
            data_out_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else if (accept) begin
            state_q       <= SHIFT;
            cnt_q         <= '0;
            sr_q          <= load_shift_d;
            data_out_q    <= load_first_d;
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
            // A one-bit word is both first and last bit unless a parity bit follows.
            frame_done_q  <= (WIDTH == 1) && !PAR_EN;
`ifdef PISO_PARITY_EN
            par_q         <= ^load_data;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    frame_start_q <= 1'b0;
                    if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
                        state_q      <= PARITY;
                        data_out_q   <= par_q;
                        frame_done_q <= 1'b1;
`else
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        data_out_q   <= 1'b0;
                        out_valid_q  <= 1'b0;
                        frame_done_q <= 1'b0;
`endif
                    end else begin
                        cnt_q        <= cnt_q + ONE;
                        sr_q         <= sr_shift_d;
                        data_out_q   <= sr_next_d;
                        frame_done_q <= ((cnt_q + ONE) == LAST) && !PAR_EN;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    cnt_q         <= '0;
                    data_out_q    <= 1'b0;
                    out_valid_q   <= 1'b0;
                    frame_start_q <= 1'b0;
                    frame_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out    = data_out_q;
    assign out_valid   = out_valid_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: two serializers (4-bit MSB-first, 8-bit LSB-first) against a frame-list model plus directed literals.
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
// Covers reset, single word, back-to-back, busy rejection, async reset mid-frame, LSB-first and parity builds.
module tb_piso_shifter;

    localparam int WA = 4;
    localparam int WB = 8;
`ifdef PISO_PARITY_EN
    localparam int PB = 1;
    localparam logic [31:0] E1 = 32'b10111;
    localparam logic [31:0] E2 = 32'b1011101100;
    localparam logic [31:0] E3 = 32'b1100000110;
    localparam logic [31:0] E4 = 32'b00011;
    localparam logic [31:0] E5 = 32'b101001010;
`else
    localparam int PB = 0;
    localparam logic [31:0] E1 = 32'b1011;
    localparam logic [31:0] E2 = 32'b10110110;
    localparam logic [31:0] E3 = 32'b11000011;
    localparam logic [31:0] E4 = 32'b0001;
    localparam logic [31:0] E5 = 32'b10100101;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn = 1'b1;
    logic          lv_a = 1'b0;
    logic [WA-1:0] ld_a = '0;
    logic          lr_a, do_a, ov_a, fs_a, fd_a;
    logic          lv_b = 1'b0;
    logic [WB-1:0] ld_b = '0;
    logic          lr_b, do_b, ov_b, fs_b, fd_b;

    piso_shifter #(.WIDTH(WA), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .resetn(resetn), .load_valid(lv_a), .load_ready(lr_a), .load_data(ld_a),
        .data_out(do_a), .out_valid(ov_a), .frame_start(fs_a), .frame_done(fd_a));

    piso_shifter #(.WIDTH(WB), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .resetn(resetn), .load_valid(lv_b), .load_ready(lr_b), .load_data(ld_b),
        .data_out(do_b), .out_valid(ov_b), .frame_start(fs_b), .frame_done(fd_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted word becomes a list of frame bits in send order; fpos walks it (-1 = idle).
    logic [32:0] fb[2];
    int          flen[2] = '{1, 1};
    int          fpos[2] = '{-1, -1};

    function automatic logic [32:0] build(input logic [31:0] w, input int n, input bit msb);
        logic [32:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[i] = msb ? w[n-1-i] : w[i];
        if (PB == 1) b[n] = ^w;
        return b;
    endfunction

    function automatic bit m_ready(input int ch);
        return (fpos[ch] < 0) || (fpos[ch] == flen[ch] - 1);
    endfunction

    always @(posedge clk or negedge resetn) begin : model
        logic        v;
        logic [31:0] w;
        int          n;
        if (!resetn) begin
            fpos[0] = -1;
            fpos[1] = -1;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                v = (ch == 0) ? lv_a : lv_b;
                w = (ch == 0) ? 32'(ld_a) : 32'(ld_b);
                n = (ch == 0) ? WA : WB;
                if (v && m_ready(ch)) begin
                    fb[ch]   = build(w, n, ch == 0);
                    flen[ch] = n + PB;
                    fpos[ch] = 0;
                end else if (fpos[ch] >= 0) begin
                    fpos[ch] = (fpos[ch] == flen[ch] - 1) ? -1 : fpos[ch] + 1;
                end
            end
        end
    end

    // Captured serial stream per channel, first bit ends up most significant.
    logic [31:0] cap[2];
    int          ncap[2], nfs[2], nfd[2], fdpos[2], run[2], maxrun[2];
    logic [3:0]  sipo;

    task automatic clr();
        for (int ch = 0; ch < 2; ch++) begin
            cap[ch] = '0; ncap[ch] = 0; nfs[ch] = 0; nfd[ch] = 0;
            fdpos[ch] = 0; run[ch] = 0; maxrun[ch] = 0;
        end
        sipo = '0;
    endtask

    // Compare process: every falling edge, both channels, all outputs; act = {ready, valid, start, done, data}.
    always @(negedge clk) begin : cmp
        logic [4:0] act;
        logic [4:0] exp;
        for (int ch = 0; ch < 2; ch++) begin
            act = (ch == 0) ? {lr_a, ov_a, fs_a, fd_a, do_a} : {lr_b, ov_b, fs_b, fd_b, do_b};
            if (fpos[ch] < 0) exp = 5'b10000;
            else exp = {fpos[ch] == flen[ch] - 1, 1'b1, fpos[ch] == 0,
                        fpos[ch] == flen[ch] - 1, fb[ch][fpos[ch]]};
            chk((ch == 0) ? "cycle_a" : "cycle_b", 32'(act), 32'(exp));
            if (act[3]) begin
                cap[ch] = {cap[ch][30:0], act[0]};
                ncap[ch]++;
                run[ch]++;
                if (run[ch] > maxrun[ch]) maxrun[ch] = run[ch];
                if (act[2]) nfs[ch]++;
                if (act[1]) begin nfd[ch]++; fdpos[ch] = ncap[ch]; end
            end else begin
                run[ch] = 0;
            end
        end
        if (ov_a) sipo = {sipo[2:0], do_a};
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clr();
        #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(lr_a), 32'd1);
        chk("rst_valid", 32'(ov_a), 32'd0);
        #1 resetn = 1'b1;

        // 1: single word 1011
        clr();
        lv_a = 1'b1; ld_a = 4'b1011;
        tick();
        lv_a = 1'b0; ld_a = '0;
        chk("t1_busy_ready", 32'(lr_a), 32'd0);
        chk("t1_first_bit", 32'({ov_a, fs_a, do_a}), 32'b111);
        repeat (WA + PB + 2) tick();
        chk("t1_bits", cap[0], E1);
        chk("t1_len", ncap[0], WA + PB);
        chk("t1_starts", nfs[0], 1);
        chk("t1_done_pos", fdpos[0], WA + PB);
        chk("t1_idle", 32'({lr_a, ov_a, fs_a, fd_a, do_a}), 32'b10000);
`ifndef PISO_PARITY_EN
        chk("t1_sipo", 32'(sipo), 32'b1011);
`endif

        // 2: back-to-back 1011 then 0110
        clr();
        lv_a = 1'b1; ld_a = 4'b1011;
        tick();
        ld_a = 4'b0110;
        repeat (WA + PB) tick();
        lv_a = 1'b0;
        repeat (WA + PB + 2) tick();
        chk("t2_bits", cap[0], E2);
        chk("t2_starts", nfs[0], 2);
        chk("t2_run", maxrun[0], 2 * (WA + PB));

        // 3: busy rejection, 0011 presented during 1100
        clr();
        lv_a = 1'b1; ld_a = 4'b1100;
        tick();
        ld_a = 4'b0011;
        repeat (WA + PB - 1) tick();
        chk("t3_final_cycle", 32'({fd_a, lr_a}), 32'b11);
        tick();
        lv_a = 1'b0;
        repeat (WA + PB + 2) tick();
        chk("t3_bits", cap[0], E3);
        chk("t3_len", ncap[0], 2 * (WA + PB));

        // 4: asynchronous reset at bit 2 of 1111
        lv_a = 1'b1; ld_a = 4'b1111;
        tick();
        lv_a = 1'b0;
        tick();
        chk("t4_bit2_live", 32'({ov_a, do_a}), 32'b11);
        resetn = 1'b0;
        #1;
        chk("t4_async_drop", 32'({ov_a, do_a, fs_a, fd_a}), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        #1;
        chk("t4_ready_after", 32'(lr_a), 32'd1);
        clr();
        lv_a = 1'b1; ld_a = 4'b0001;
        tick();
        lv_a = 1'b0;
        repeat (WA + PB + 2) tick();
        chk("t4_bits", cap[0], E4);
        chk("t4_len", ncap[0], WA + PB);

        // 5: LSB-first 8-bit A5
        clr();
        lv_b = 1'b1; ld_b = 8'hA5;
        tick();
        lv_b = 1'b0;
        repeat (WB + PB + 2) tick();
        chk("t5_bits", cap[1], E5);
        chk("t5_done_pos", fdpos[1], WB + PB);
        chk("t5_dones", nfd[1], 1);

`ifdef PISO_PARITY_EN
        // 6: parity bits for 1011 and 1001
        clr();
        lv_a = 1'b1; ld_a = 4'b1011;
        tick();
        lv_a = 1'b0;
        repeat (WA + 3) tick();
        chk("t6_bits_1011", cap[0], 32'b10111);
        chk("t6_done_pos", fdpos[0], 5);
        clr();
        lv_a = 1'b1; ld_a = 4'b1001;
        tick();
        lv_a = 1'b0;
        repeat (WA + 3) tick();
        chk("t6_bits_1001", cap[0], 32'b10010);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
